// File: rtl/niios_qsys_nios2_mul_issue.sv
// Issue and result-buffer stage in front of the Nios II multiply cell.
// Credit-based issue guarantees every multiply in flight has a FIFO slot.
module niios_qsys_nios2_mul_issue #(
  parameter int MUL_LATENCY = 1,
  parameter int FIFO_DEPTH  = 2,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [31:0]      A_mul_src1,
  output logic [31:0]      A_mul_src2,
  input  logic [31:0]      A_mul_cell_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(MUL_LATENCY + 1);
  localparam int SW = 5;

  logic [MUL_LATENCY-1:0] vpipe;
  logic [TAG_W-1:0]       tpipe [MUL_LATENCY];
  logic [31:0]            mem_d [FIFO_DEPTH];
  logic [TAG_W-1:0]       mem_t [FIFO_DEPTH];
  logic [PW-1:0]          rptr;
  logic [PW-1:0]          wptr;
  logic [CW-1:0]          count;
  logic [IW-1:0]          inflight;
  logic [SW-1:0]          used;
  logic                   issue;
  logic                   pop;
  logic                   wr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign A_mul_src1 = in_src1;
  assign A_mul_src2 = in_src2;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_LATENCY; i++)
      inflight = inflight + IW'(vpipe[i]);
  end

  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  // pop only when count > 0, so the subtraction cannot underflow
  assign used       = SW'(count) + SW'(inflight) - SW'(pop);
  assign in_ready   = ~flush & (used < SW'(FIFO_DEPTH));
  assign issue      = in_valid & in_ready;
  assign wr         = vpipe[MUL_LATENCY-1] & ~flush;
  assign out_result = mem_d[rptr];
  assign out_tag    = mem_t[rptr];
  assign busy       = (inflight != '0) | (count != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpipe <= '0;
      for (int i = 0; i < MUL_LATENCY; i++)
        tpipe[i] <= '0;
    end else if (flush) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= issue;
      tpipe[0] <= in_tag;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        tpipe[i] <= tpipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_t[i] <= '0;
      end
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem_d[wptr] <= A_mul_cell_result;
        mem_t[wptr] <= tpipe[MUL_LATENCY-1];
        wptr        <= nxt(wptr);
      end
      if (pop)
        rptr <= nxt(rptr);
      unique case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(wr && count == CW'(FIFO_DEPTH))
  );

endmodule

// File: tb/tb_niios_qsys_nios2_mul_issue.sv
// Randomised bench: queue-based timing model plus a behavioural multiply cell.
// Directed sequences first, then random traffic with flushes and a reset.
module tb_niios_qsys_nios2_mul_issue;

  localparam int L  = 1;
  localparam int D  = 2;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_src1 = '0;
  logic [31:0]   in_src2 = '0;
  logic [TW-1:0] in_tag = '0;
  logic          flush = 1'b0;
  logic [31:0]   A_mul_src1;
  logic [31:0]   A_mul_src2;
  logic [31:0]   A_mul_cell_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_result;
  logic [TW-1:0] out_tag;
  logic          busy;

  always #5 clk = ~clk;

  niios_qsys_nios2_mul_issue #(
    .MUL_LATENCY(L),
    .FIFO_DEPTH (D),
    .TAG_W      (TW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_src1          (in_src1),
    .in_src2          (in_src2),
    .in_tag           (in_tag),
    .flush            (flush),
    .A_mul_src1       (A_mul_src1),
    .A_mul_src2       (A_mul_src2),
    .A_mul_cell_result(A_mul_cell_result),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_tag          (out_tag),
    .busy             (busy)
  );

  // multiply cell: L-deep registered product, low 32 bits
  logic [31:0] cell_q [L];
  always @(posedge clk) begin
    cell_q[0] <= A_mul_src1 * A_mul_src2;
    for (int i = 1; i < L; i++)
      cell_q[i] <= cell_q[i-1];
  end
  assign A_mul_cell_result = cell_q[L-1];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0]   r;
    logic [TW-1:0] t;
    int            c;
  } ent_t;

  ent_t fq[$];
  ent_t iq[$];

  task automatic step(input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic [TW-1:0] tg,
                      input logic ordy, input logic fl);
    bit   pe, re, acc;
    int   u;
    ent_t e;
    @(negedge clk);
    in_valid = v; in_src1 = a; in_src2 = b; in_tag = tg;
    out_ready = ordy; flush = fl;
    #1;
    pe  = (fq.size() > 0) && ordy;
    u   = fq.size() + iq.size() - int'(pe);
    re  = !fl && (u < D);
    acc = v && re;
    chk("in_ready", 32'(in_ready), 32'(re));
    chk("out_valid", 32'(out_valid), 32'(fq.size() > 0));
    chk("busy", 32'(busy), 32'((fq.size() + iq.size()) > 0));
    chk("src1", A_mul_src1, a);
    if (fq.size() > 0) begin
      chk("out_result", out_result, fq[0].r);
      chk("out_tag", 32'(out_tag), 32'(fq[0].t));
    end
    @(posedge clk);
    if (fl) begin
      fq.delete();
      iq.delete();
    end else begin
      if (pe) void'(fq.pop_front());
      foreach (iq[i]) iq[i].c = iq[i].c - 1;
      while (iq.size() > 0 && iq[0].c == 0)
        fq.push_back(iq.pop_front());
      if (acc) begin
        e.r = a * b;
        e.t = tg;
        e.c = L;
        iq.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, '0, ordy, 1'b0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_tag", 32'(out_tag), 32'h0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #3 reset_n = 1'b0;
    #1 chk_reset_vals();
    fq.delete();
    iq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0001_0000;
      2:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #12 chk_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;

    step(1'b1, 32'd3, 32'd5, 5'd7, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0);
    step(1'b1, 32'h0001_0000, 32'h0001_0000, 5'd2, 1'b1, 1'b0);
    step(1'b1, 32'h0001_2345, 32'h10, 5'd3, 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    for (int i = 0; i < 16; i++)
      step(1'b1, $urandom, $urandom, TW'(i), 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    for (int i = 0; i < 5; i++)
      step(1'b1, $urandom, $urandom, TW'(20 + i), 1'b0, 1'b0);
    repeat (4) idle(1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, $urandom, $urandom, TW'(10 + i), 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    step(1'b1, 32'd6, 32'd7, 5'd4, 1'b0, 1'b0);
    step(1'b1, 32'd8, 32'd9, 5'd5, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    repeat (3) idle(1'b1);

    for (int i = 0; i < 3; i++)
      step(1'b1, $urandom, $urandom, TW'(i), 1'b0, 1'b0);
    async_reset();
    repeat (3) idle(1'b1);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      step($urandom_range(0, 3) != 0, pick(), pick(), TW'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    repeat (4) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
